// File: rtl/rob_retire_pkg.sv
// rtl/rob_retire_pkg.sv - shared ROB entry layout and retire-stage types
package rob_retire_pkg;

    localparam int XLEN          = 32;
    localparam int ARF_ID_WIDTH  = 5;
    localparam int ROB_PTR_WIDTH = 3;
    localparam int ENTRY_WIDTH   = 3 + ARF_ID_WIDTH + 2 * XLEN;

    // Bit offsets of each field inside a packed ROB entry (LSB side first)
    localparam int TPC_LSB      = 0;
    localparam int RESULT_LSB   = TPC_LSB + XLEN;
    localparam int ARF_ID_LSB   = RESULT_LSB + XLEN;
    localparam int REDIRECT_BIT = ARF_ID_LSB + ARF_ID_WIDTH;
    localparam int HAS_DEST_BIT = REDIRECT_BIT + 1;
    localparam int DONE_BIT     = HAS_DEST_BIT + 1;

    typedef struct packed {
        logic                    done;
        logic                    has_dest;
        logic                    redirect;
        logic [ARF_ID_WIDTH-1:0] arf_id;
        logic [XLEN-1:0]         result;
        logic [XLEN-1:0]         target_pc;
    } rob_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } retire_state_t;

endpackage

// File: rtl/rob_retire_flush_timer.sv
// rtl/rob_retire_flush_timer.sv - loadable 4-bit down-counter timing the flush drain window
module flush_timer (
    input  logic       clk,
    input  logic       rst_aL,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] count,
    output logic       last
);

    // Load on request, otherwise count down and rest at zero
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign last = (count == 4'd1);

endmodule

// File: rtl/rob_retire_reg.sv
// rtl/rob_retire_reg.sv - enabled register primitive with async active-low clear
module rob_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_aL,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d when enabled, clear asynchronously on reset
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rob_retire.sv
// rtl/rob_retire.sv - in-order ROB commit stage with ARF write and flush/redirect
module rob_retire
    import rob_retire_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int ARF_ID_WIDTH  = 5,
    parameter int ROB_PTR_WIDTH = 3,
    parameter int FLUSH_CYCLES  = 2,
    parameter int ENTRY_WIDTH   = 3 + ARF_ID_WIDTH + 2 * XLEN
) (
    input  logic                     clk,
    input  logic                     rst_aL,
    input  logic                     rob_deq_valid,
    input  logic [ENTRY_WIDTH-1:0]   rob_deq_data,
    input  logic [ROB_PTR_WIDTH-1:0] rob_deq_addr,
    output logic                     rob_deq_ready,
    input  logic                     arf_stall,
    output logic                     arf_we,
    output logic [ARF_ID_WIDTH-1:0]  arf_waddr,
    output logic [XLEN-1:0]          arf_wdata,
    output logic                     flush,
    output logic [XLEN-1:0]          redirect_pc,
    output logic [ROB_PTR_WIDTH-1:0] flush_rob_id,
    output logic [31:0]              retired_count
);

    // Field offsets follow the shared entry layout but track this instance's widths
    localparam int OFS_TPC    = 0;
    localparam int OFS_RESULT = OFS_TPC + XLEN;
    localparam int OFS_ARF_ID = OFS_RESULT + XLEN;
    localparam int OFS_REDIR  = OFS_ARF_ID + ARF_ID_WIDTH;
    localparam int OFS_HDEST  = OFS_REDIR + 1;
    localparam int OFS_DONE   = OFS_HDEST + 1;

    logic                    head_done;
    logic                    head_has_dest;
    logic                    head_redirect;
    logic [ARF_ID_WIDTH-1:0] head_arf_id;
    logic [XLEN-1:0]         head_result;
    logic [XLEN-1:0]         head_tpc;

    assign head_done     = rob_deq_data[OFS_DONE];
    assign head_has_dest = rob_deq_data[OFS_HDEST];
    assign head_redirect = rob_deq_data[OFS_REDIR];
    assign head_arf_id   = rob_deq_data[OFS_ARF_ID +: ARF_ID_WIDTH];
    assign head_result   = rob_deq_data[OFS_RESULT +: XLEN];
    assign head_tpc      = rob_deq_data[OFS_TPC +: XLEN];

    retire_state_t state;
    logic          retire;
    logic          arf_write;
    logic          take_flush;
    logic [3:0]    timer_count;
    logic          timer_last;
    logic [31:0]   count_q;

    // Ready is forced low while reset is held so nothing is consumed during reset
    assign retire        = rst_aL & rob_deq_valid & head_done & ~arf_stall & (state == RUN);
    assign rob_deq_ready = retire;
    assign arf_write     = retire & head_has_dest & (head_arf_id != '0);
    assign take_flush    = retire & head_redirect;

    flush_timer u_flush_timer (
        .clk      (clk),
        .rst_aL   (rst_aL),
        .load     (take_flush),
        .load_val (4'(FLUSH_CYCLES)),
        .count    (timer_count),
        .last     (timer_last)
    );

    // RUN -> FLUSH on a redirecting retire; leave on the final blocked cycle
    // (a zero count also exits, so a stray zero load can never wedge the stage)
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state <= RUN;
        end else if (state == RUN) begin
            if (take_flush) begin
                state <= FLUSH;
            end
        end else if (timer_last || (timer_count == 4'd0)) begin
            state <= RUN;
        end
    end

    rob_reg #(.W(1)) u_arf_we (
        .clk (clk), .rst_aL (rst_aL), .en (1'b1), .d (arf_write), .q (arf_we)
    );

    rob_reg #(.W(ARF_ID_WIDTH + XLEN)) u_arf_wr (
        .clk (clk), .rst_aL (rst_aL), .en (arf_write),
        .d ({head_arf_id, head_result}), .q ({arf_waddr, arf_wdata})
    );

    rob_reg #(.W(1)) u_flush (
        .clk (clk), .rst_aL (rst_aL), .en (1'b1), .d (take_flush), .q (flush)
    );

    rob_reg #(.W(XLEN + ROB_PTR_WIDTH)) u_redirect (
        .clk (clk), .rst_aL (rst_aL), .en (take_flush),
        .d ({head_tpc, rob_deq_addr}), .q ({redirect_pc, flush_rob_id})
    );

    // Debug retire counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            count_q <= 32'd0;
        end else if (retire) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign retired_count = count_q;

endmodule

// File: tb/tb_rob_retire.sv
// tb/tb_rob_retire.sv - directed self-checking bench for rob_retire
module tb_rob_retire;
    import rob_retire_pkg::*;

    logic                     clk;
    logic                     rst_aL;
    logic                     rob_deq_valid;
    logic [ENTRY_WIDTH-1:0]   rob_deq_data;
    logic [ROB_PTR_WIDTH-1:0] rob_deq_addr;
    logic                     rob_deq_ready;
    logic                     arf_stall;
    logic                     arf_we;
    logic [ARF_ID_WIDTH-1:0]  arf_waddr;
    logic [XLEN-1:0]          arf_wdata;
    logic                     flush;
    logic [XLEN-1:0]          redirect_pc;
    logic [ROB_PTR_WIDTH-1:0] flush_rob_id;
    logic [31:0]              retired_count;

    int tests;
    int fails;

    rob_retire dut (
        .clk           (clk),
        .rst_aL        (rst_aL),
        .rob_deq_valid (rob_deq_valid),
        .rob_deq_data  (rob_deq_data),
        .rob_deq_addr  (rob_deq_addr),
        .rob_deq_ready (rob_deq_ready),
        .arf_stall     (arf_stall),
        .arf_we        (arf_we),
        .arf_waddr     (arf_waddr),
        .arf_wdata     (arf_wdata),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .flush_rob_id  (flush_rob_id),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ENTRY_WIDTH-1:0] mk(input logic d, input logic hd, input logic rd,
                                                  input logic [4:0] id, input logic [31:0] res,
                                                  input logic [31:0] tpc);
        rob_entry_t e;
        e.done = d; e.has_dest = hd; e.redirect = rd;
        e.arf_id = id; e.result = res; e.target_pc = tpc;
        return e;
    endfunction

    task automatic head(input logic v, input logic [2:0] addr, input logic [ENTRY_WIDTH-1:0] e);
        rob_deq_valid = v;
        rob_deq_addr  = addr;
        rob_deq_data  = e;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_we"}, 64'(arf_we), 64'(we));
        chk({tag, "_waddr"}, 64'(arf_waddr), 64'(a));
        chk({tag, "_wdata"}, 64'(arf_wdata), 64'(d));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_aL = 1'b0;
        arf_stall = 1'b0;
        rob_deq_valid = 1'b0;
        rob_deq_addr = '0;
        rob_deq_data = '0;

        // Reset state, with a retirable head present
        @(negedge clk);
        head(1'b1, 3'd0, mk(1, 1, 0, 5'd5, 32'h11, 32'h0));
        chk("rst_ready", 64'(rob_deq_ready), 64'd0);
        chk_wr("rst", 1'b0, 5'd0, 32'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_pc", 64'(redirect_pc), 64'd0);
        chk("rst_robid", 64'(flush_rob_id), 64'd0);
        chk("rst_count", 64'(retired_count), 64'd0);
        rst_aL = 1'b1;
        #1;

        // Back-to-back retire
        chk("b2b_ready0", 64'(rob_deq_ready), 64'd1);
        tick();
        chk_wr("b2b0", 1'b1, 5'd5, 32'h11);
        head(1'b1, 3'd1, mk(1, 1, 0, 5'd6, 32'h22, 32'h0));
        chk("b2b_ready1", 64'(rob_deq_ready), 64'd1);
        tick();
        chk_wr("b2b1", 1'b1, 5'd6, 32'h22);
        head(1'b1, 3'd2, mk(1, 1, 0, 5'd0, 32'h33, 32'h0));
        chk("b2b_ready2", 64'(rob_deq_ready), 64'd1);
        tick();
        chk_wr("b2b2_x0", 1'b0, 5'd6, 32'h22);
        chk("b2b_count", 64'(retired_count), 64'd3);
        head(1'b0, 3'd3, '0);
        tick();
        chk("idle_we", 64'(arf_we), 64'd0);

        // Head not done for 4 cycles
        head(1'b1, 3'd3, mk(0, 1, 0, 5'd7, 32'h44, 32'h0));
        for (int i = 0; i < 4; i++) begin
            chk("nd_ready", 64'(rob_deq_ready), 64'd0);
            tick();
            chk("nd_we", 64'(arf_we), 64'd0);
        end
        head(1'b1, 3'd3, mk(1, 1, 0, 5'd7, 32'h44, 32'h0));
        chk("nd_ready5", 64'(rob_deq_ready), 64'd1);
        tick();
        chk_wr("nd_wr", 1'b1, 5'd7, 32'h44);
        chk("nd_count", 64'(retired_count), 64'd4);
        head(1'b0, 3'd3, '0);
        tick();
        chk("nd_single", 64'(arf_we), 64'd0);

        // Redirect with link write, then 2 blocked cycles
        head(1'b1, 3'd3, mk(1, 1, 1, 5'd1, 32'h104, 32'h2000));
        chk("rd_ready", 64'(rob_deq_ready), 64'd1);
        tick();
        chk("rd_flush", 64'(flush), 64'd1);
        chk("rd_pc", 64'(redirect_pc), 64'h2000);
        chk("rd_robid", 64'(flush_rob_id), 64'd3);
        chk_wr("rd_link", 1'b1, 5'd1, 32'h104);
        head(1'b1, 3'd4, mk(1, 1, 0, 5'd2, 32'h55, 32'h0));
        chk("rd_blk1", 64'(rob_deq_ready), 64'd0);
        tick();
        chk("rd_flush_off", 64'(flush), 64'd0);
        chk("rd_we_off", 64'(arf_we), 64'd0);
        chk("rd_blk2", 64'(rob_deq_ready), 64'd0);
        tick();
        chk("rd_resume", 64'(rob_deq_ready), 64'd1);
        tick();
        chk_wr("rd_next", 1'b1, 5'd2, 32'h55);
        chk("rd_count", 64'(retired_count), 64'd6);
        head(1'b0, 3'd0, '0);
        tick();

        // ARF stall blocks retire for 2 cycles
        arf_stall = 1'b1;
        head(1'b1, 3'd5, mk(1, 1, 0, 5'd3, 32'h66, 32'h0));
        for (int i = 0; i < 2; i++) begin
            chk("st_ready", 64'(rob_deq_ready), 64'd0);
            tick();
            chk("st_we", 64'(arf_we), 64'd0);
        end
        arf_stall = 1'b0;
        #1;
        chk("st_release", 64'(rob_deq_ready), 64'd1);
        tick();
        chk_wr("st_wr", 1'b1, 5'd3, 32'h66);
        chk("st_count", 64'(retired_count), 64'd7);
        // A stall raised after a retire must not hold back its write
        head(1'b1, 3'd6, mk(1, 1, 0, 5'd4, 32'h77, 32'h0));
        tick();
        arf_stall = 1'b1;
        head(1'b1, 3'd7, mk(1, 1, 0, 5'd8, 32'h88, 32'h0));
        chk("st2_ready", 64'(rob_deq_ready), 64'd0);
        chk_wr("st2_wr", 1'b1, 5'd4, 32'h77);
        arf_stall = 1'b0;
        head(1'b0, 3'd0, '0);
        tick();

        // Reset one cycle after the flush pulse
        head(1'b1, 3'd2, mk(1, 0, 1, 5'd0, 32'h0, 32'h3000));
        tick();
        chk("rm_flush", 64'(flush), 64'd1);
        chk("rm_pc", 64'(redirect_pc), 64'h3000);
        head(1'b1, 3'd3, mk(1, 1, 0, 5'd9, 32'h99, 32'h0));
        tick();
        rst_aL = 1'b0;
        #1;
        chk("rm_ready", 64'(rob_deq_ready), 64'd0);
        chk_wr("rm", 1'b0, 5'd0, 32'd0);
        chk("rm_flush0", 64'(flush), 64'd0);
        chk("rm_pc0", 64'(redirect_pc), 64'd0);
        chk("rm_robid0", 64'(flush_rob_id), 64'd0);
        chk("rm_count0", 64'(retired_count), 64'd0);
        @(negedge clk);
        rst_aL = 1'b1;
        #1;
        chk("rm_run_ready", 64'(rob_deq_ready), 64'd1);
        tick();
        chk_wr("rm_wr", 1'b1, 5'd9, 32'h99);
        chk("rm_count1", 64'(retired_count), 64'd1);

        // Counter wrap
        head(1'b0, 3'd0, '0);
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        #1;
        chk("wrap_pre", 64'(retired_count), 64'hFFFF_FFFF);
        head(1'b1, 3'd1, mk(1, 0, 0, 5'd0, 32'h0, 32'h0));
        tick();
        chk("wrap_count", 64'(retired_count), 64'd0);
        head(1'b0, 3'd0, '0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
